block_scheduler: RTL
====================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, maximum threads per block (power of two, >=1).
REQ-003 SHALL have parameter TC_W, default 16, width of thread_count.
REQ-004 SHALL have parameter BID_W, default 16, width of block ids and block counters.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port launch  input  1  one-cycle kernel launch request.
REQ-008 SHALL have port abort  input  1  stop issuing new blocks; drain outstanding ones.
REQ-009 SHALL have port thread_count  input  TC_W  total threads; sampled on accepted launch.
REQ-010 SHALL have port core_enable  input  NUM_CORES  cores eligible for this kernel; sampled on accepted launch.
REQ-011 SHALL have port core_done  input  NUM_CORES  per-core block completion.
REQ-012 SHALL have port core_start  output  NUM_CORES  per-core run request, level.
REQ-013 SHALL have port core_reset  output  NUM_CORES  per-core one-cycle reset pulse.
REQ-014 SHALL have port core_block_id  output  NUM_CORES x BID_W  block id per core.
REQ-015 SHALL have port core_thread_count  output  NUM_CORES x (clog2(THREADS_PER_BLOCK)+1)  active threads in the assigned block.
REQ-016 SHALL have ports busy, done, aborted  output  1 each  kernel status.
REQ-017 SHALL have ports blocks_issued, blocks_retired  output  BID_W each  progress counters.

Function
REQ-018 SHALL implement top FSM IDLE, RUN, DRAIN, DONE.
REQ-019 SHALL accept launch only in IDLE or DONE; launch is ignored in RUN or DRAIN.
REQ-020 On an accepted launch it SHALL latch thread_count and core_enable, clear the counters, done and aborted, and enter RUN.
REQ-021 SHALL compute total_blocks = ceil(thread_count / THREADS_PER_BLOCK) in BID_W+1 bits without overflow.
REQ-022 If the latched thread_count is 0 or core_enable is 0, it SHALL enter DONE one cycle after launch and dispatch no blocks.
REQ-023 Each core SHALL have a sub-state of FREE, RUNNING or RESETTING.
REQ-024 In RUN it SHALL grant at most one block per cycle to an enabled FREE core, chosen round-robin starting after the last granted core.
REQ-025 On a grant, from the next cycle it SHALL hold core_start[i]=1, core_block_id[i]=blocks_issued and core_thread_count[i]=THREADS_PER_BLOCK, or the remainder thread_count-id*THREADS_PER_BLOCK for the last block; it SHALL then increment blocks_issued.
REQ-026 core_start[i] and core_block_id[i] SHALL stay stable until core_done[i] is sampled high while the core is RUNNING.
REQ-027 On completion it SHALL drive core_start[i]=0 and core_reset[i]=1 for exactly one cycle, then set the core FREE; a FREE core is grantable in the cycle after that.
REQ-028 SHALL ignore core_done[i] when the core is not RUNNING.
REQ-029 When several cores complete in the same cycle, it SHALL add all of them to blocks_retired in that cycle.
REQ-030 A grant and a completion in the same cycle SHALL both take effect.
REQ-031 RUN SHALL go to DRAIN when blocks_issued == total_blocks, or on abort (abort in RUN sets aborted=1).
REQ-032 DRAIN SHALL go to DONE when no core is RUNNING or RESETTING.
REQ-033 If abort and the final grant occur in the same cycle, the grant SHALL take effect and aborted SHALL be set.
REQ-034 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-035 done SHALL be 1 exactly in DONE and held until the next accepted launch.

Reset
REQ-036 Reset SHALL set the FSM to IDLE, all cores FREE, core_start=0, core_reset=all ones for the reset cycles, ids, counters, done, aborted and busy to 0, core_thread_count to THREADS_PER_BLOCK, and the round-robin pointer to core 0.
REQ-037 Reset SHALL override all other inputs, including mid-kernel; no block state is retained.

Structure
REQ-038 The FSM state enum and the per-core state enum SHALL live in the shared package gpu_dispatch_pkg.
REQ-039 Core selection SHALL be a sub-module rr_arbiter (NUM_CORES request/grant, one-hot grant, pointer advance on grant).

Verification
REQ-040 NUM_CORES=4, TPB=4, thread_count=10, all enabled: blocks 0,1,2 go to cores 0,1,2 on consecutive cycles, block 2 carries thread_count 2, and done follows the third retire.
REQ-041 thread_count=0 launch: done=1 two cycles later, core_start never asserted.
REQ-042 core_enable=4'b0101, thread_count=16: only cores 0 and 2 start, each runs 2 blocks, blocks_retired=4.
REQ-043 Cores 1 and 3 assert core_done in the same cycle: blocks_retired increases by 2, and each core gets a one-cycle core_reset.
REQ-044 abort after 2 of 8 blocks issued: no further grants, outstanding blocks drain, then done=1, aborted=1, blocks_issued=2.
REQ-045 Reset asserted in RUN: next cycle IDLE, core_start=0, counters 0; a following launch runs normally.

Source files
------------

// File: rtl/gpu_dispatch_pkg.sv
// Shared types for the GPU block dispatcher: kernel-level FSM states and per-core states.
package gpu_dispatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    CoreFree      = 2'd0,
    CoreRunning   = 2'd1,
    CoreResetting = 2'd2
  } core_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the core after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PtrW'((32'(ptr_q) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_d    = (32'(idx) == N - 1) ? '0 : idx + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a launch into fixed-size thread blocks and hands them
// round-robin to enabled cores, tracking issue/retire progress and abort/drain.
module block_scheduler
  import gpu_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned TC_W              = 16,
  parameter int unsigned BID_W             = 16
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    launch,
  input  logic                                                    abort,
  input  logic [TC_W-1:0]                                         thread_count,
  input  logic [NUM_CORES-1:0]                                    core_enable,
  input  logic [NUM_CORES-1:0]                                    core_done,
  output logic [NUM_CORES-1:0]                                    core_start,
  output logic [NUM_CORES-1:0]                                    core_reset,
  output logic [NUM_CORES-1:0][BID_W-1:0]                         core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]       core_thread_count,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    aborted,
  output logic [BID_W-1:0]                                        blocks_issued,
  output logic [BID_W-1:0]                                        blocks_retired
);

  localparam int unsigned Log2Tpb = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned CntW    = Log2Tpb + 1;
  localparam int unsigned TotW    = BID_W + 1;
  localparam int unsigned SumW    = TC_W + 1;

  sched_state_e                       state_q, state_d;
  core_state_e                        core_st_q [NUM_CORES];
  core_state_e                        core_st_d [NUM_CORES];
  logic [NUM_CORES-1:0]               en_q, en_d;
  logic [TC_W-1:0]                    tc_q, tc_d;
  logic [TotW-1:0]                    total_q, total_d;
  logic [BID_W-1:0]                   issued_q, issued_d;
  logic [BID_W-1:0]                   retired_q, retired_d;
  logic                               aborted_q, aborted_d;
  logic [NUM_CORES-1:0][BID_W-1:0]    bid_q, bid_d;
  logic [NUM_CORES-1:0][CntW-1:0]     tcnt_q, tcnt_d;

  logic [NUM_CORES-1:0] req, gnt, finish;
  logic                 launch_ok, all_free, zero_kernel, last_block, issue_left;
  logic [SumW-1:0]      tc_round;
  logic [TotW-1:0]      launch_total;
  logic [TC_W-1:0]      rem;
  logic [CntW-1:0]      last_cnt, grant_cnt;

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  // Ceiling division in TC_W+1 bits so the rounding add cannot overflow.
  always_comb begin
    tc_round     = {1'b0, thread_count} + SumW'(THREADS_PER_BLOCK - 1);
    launch_total = TotW'(tc_round >> Log2Tpb);
  end

  // The last block carries the remainder, or a full block when the count divides evenly.
  always_comb begin
    rem         = tc_q & TC_W'(THREADS_PER_BLOCK - 1);
    last_cnt    = (rem == '0) ? CntW'(THREADS_PER_BLOCK) : CntW'(rem);
    last_block  = ({1'b0, issued_q} == total_q - TotW'(1));
    grant_cnt   = last_block ? last_cnt : CntW'(THREADS_PER_BLOCK);
    zero_kernel = (total_q == '0) || (en_q == '0);
    issue_left  = ({1'b0, issued_q} != total_q);
  end

  always_comb begin
    all_free = 1'b1;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      req[i]    = (state_q == StRun) && !zero_kernel && issue_left && en_q[i] &&
                  (core_st_q[i] == CoreFree);
      finish[i] = (core_st_q[i] == CoreRunning) && core_done[i];
      if (core_st_q[i] != CoreFree) all_free = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_st_d[i] = core_st_q[i];
      bid_d[i]     = bid_q[i];
      tcnt_d[i]    = tcnt_q[i];
      unique case (core_st_q[i])
        CoreFree: begin
          if (gnt[i]) begin
            core_st_d[i] = CoreRunning;
            bid_d[i]     = issued_q;
            tcnt_d[i]    = grant_cnt;
          end
        end
        CoreRunning:   if (core_done[i]) core_st_d[i] = CoreResetting;
        CoreResetting: core_st_d[i] = CoreFree;
        default:       core_st_d[i] = CoreFree;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    tc_d      = tc_q;
    total_d   = total_q;
    aborted_d = aborted_q;
    issued_d  = issued_q + BID_W'(|gnt);
    retired_d = retired_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      retired_d = retired_d + BID_W'(finish[i]);
    end
    launch_ok = launch && ((state_q == StIdle) || (state_q == StDone));

    unique case (state_q)
      StIdle, StDone: begin
        if (launch_ok) begin
          state_d   = StRun;
          tc_d      = thread_count;
          en_d      = core_enable;
          total_d   = launch_total;
          issued_d  = '0;
          retired_d = '0;
          aborted_d = 1'b0;
        end
      end
      StRun: begin
        if (zero_kernel) begin
          state_d = StDone;
        end else if (abort) begin
          // A grant made in the abort cycle still stands.
          aborted_d = 1'b1;
          state_d   = StDrain;
        end else if ({1'b0, issued_d} == total_q) begin
          state_d = StDrain;
        end
      end
      StDrain: if (all_free) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      en_q      <= '0;
      tc_q      <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      aborted_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        core_st_q[i] <= CoreFree;
        bid_q[i]     <= '0;
        tcnt_q[i]    <= CntW'(THREADS_PER_BLOCK);
      end
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      tc_q      <= tc_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      aborted_q <= aborted_d;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        core_st_q[i] <= core_st_d[i];
        bid_q[i]     <= bid_d[i];
        tcnt_q[i]    <= tcnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_start[i] = (core_st_q[i] == CoreRunning);
      core_reset[i] = reset || (core_st_q[i] == CoreResetting);
    end
  end

  assign core_block_id     = bid_q;
  assign core_thread_count = tcnt_q;
  assign busy              = (state_q == StRun) || (state_q == StDrain);
  assign done              = (state_q == StDone);
  assign aborted           = aborted_q;
  assign blocks_issued     = issued_q;
  assign blocks_retired    = retired_q;

endmodule
